// File: rtl/hkspi_slave_if.sv
// rtl/hkspi_slave_if.sv - housekeeping SPI pad bundle (SCK, CSB, SDI in; SDO, sdo_enb out)
interface hkspi_slave_if;
  logic SCK;
  logic CSB;
  logic SDI;
  logic SDO;
  logic sdo_enb;

  modport master (output SCK, output CSB, output SDI, input SDO, input sdo_enb);
  modport slave  (input SCK, input CSB, input SDI, output SDO, output sdo_enb);
endinterface

// File: rtl/hkspi_slave.sv
// rtl/hkspi_slave.sv - oversampled housekeeping SPI slave with nine-entry register map
// Optional HKSPI_IRQ_EN: writing reg 6 with bit0=1 pulses irq for one clk.
module hkspi_slave #(
  parameter logic [11:0] MFGR_ID = 12'h456,
  parameter logic [7:0]  PROD_ID = 8'h05
) (
  input  logic         clk,
  input  logic         resetn,
  hkspi_slave_if.slave spi,
  output logic [2:0]   pll_ctrl,
  output logic         pll_bypass,
  output logic         irq,
  output logic         reset_ext,
  output logic [7:0]   trim
);
  typedef enum logic [2:0] {S_IDLE, S_COMMAND, S_ADDRESS, S_DATA, S_IGNORE} state_t;

  state_t     state_q, state_d;
  logic [2:0] sck_sync_q, sck_sync_d;
  logic [1:0] csb_sync_q, csb_sync_d;
  logic [1:0] sdi_sync_q, sdi_sync_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_in_q, shift_in_d;
  logic       rd_q, rd_d, wr_q, wr_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] sdo_sr_q, sdo_sr_d;
  logic [2:0] pll_ctrl_q, pll_ctrl_d;
  logic       pll_bypass_q, pll_bypass_d;
  logic       reset_ext_q, reset_ext_d;
  logic [7:0] trim_q, trim_d;
  logic       irq_q, irq_d;

  logic       sck_rise, csb_s, sdi_s, byte_done, data_rd;
  logic [7:0] byte_in, addr_next;

  assign sck_rise  = sck_sync_q[1] & ~sck_sync_q[2];
  assign csb_s     = csb_sync_q[1];
  assign sdi_s     = sdi_sync_q[1];
  assign byte_in   = {shift_in_q, sdi_s};
  assign byte_done = sck_rise && (bit_cnt_q == 3'd7);
  assign addr_next = addr_q + 8'd1;
  assign data_rd   = (state_q == S_DATA) && rd_q;

  function automatic logic [7:0] reg_read(input logic [7:0] a);
    case (a)
      8'd1:    return {4'h0, MFGR_ID[11:8]};
      8'd2:    return MFGR_ID[7:0];
      8'd3:    return PROD_ID;
      8'd4:    return {5'b0, pll_ctrl_q};
      8'd5:    return {7'b0, pll_bypass_q};
      8'd7:    return {7'b0, reset_ext_q};
      8'd8:    return trim_q;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    sck_sync_d   = {sck_sync_q[1:0], spi.SCK};
    csb_sync_d   = {csb_sync_q[0], spi.CSB};
    sdi_sync_d   = {sdi_sync_q[0], spi.SDI};
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_in_d   = shift_in_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    sdo_sr_d     = sdo_sr_q;
    pll_ctrl_d   = pll_ctrl_q;
    pll_bypass_d = pll_bypass_q;
    reset_ext_d  = reset_ext_q;
    trim_d       = trim_q;
    irq_d        = 1'b0;

    if (csb_s) begin
      // Abort: drop any partial byte but leave the register file untouched.
      state_d    = S_IDLE;
      bit_cnt_d  = 3'd0;
      shift_in_d = 7'd0;
      rd_d       = 1'b0;
      wr_d       = 1'b0;
    end else begin
      if (sck_rise && state_q != S_IDLE && state_q != S_IGNORE) begin
        bit_cnt_d  = bit_cnt_q + 3'd1;
        shift_in_d = byte_in[6:0];
        if (state_q == S_DATA) sdo_sr_d = {sdo_sr_q[6:0], 1'b0};
      end
      case (state_q)
        S_IDLE:    state_d = S_COMMAND;
        S_COMMAND: if (byte_done) begin
          rd_d    = byte_in[6];
          wr_d    = byte_in[7];
          state_d = (byte_in[7:6] == 2'b00) ? S_IGNORE : S_ADDRESS;
        end
        S_ADDRESS: if (byte_done) begin
          addr_d  = byte_in;
          if (rd_q) sdo_sr_d = reg_read(byte_in);
          state_d = S_DATA;
        end
        S_DATA: if (byte_done) begin
          if (wr_q) begin
            case (addr_q)
              8'd4: pll_ctrl_d   = byte_in[2:0];
              8'd5: pll_bypass_d = byte_in[0];
`ifdef HKSPI_IRQ_EN
              8'd6: irq_d        = byte_in[0];
`endif
              8'd7: reset_ext_d  = byte_in[0];
              8'd8: trim_d       = byte_in;
              default: ;
            endcase
          end
          addr_d = addr_next;
          // Read mux sees flop values, so read+write returns pre-write contents.
          if (rd_q) sdo_sr_d = reg_read(addr_next);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      sck_sync_q   <= 3'b000;
      csb_sync_q   <= 2'b11;
      sdi_sync_q   <= 2'b00;
      bit_cnt_q    <= 3'd0;
      shift_in_q   <= 7'd0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= 8'd0;
      sdo_sr_q     <= 8'd0;
      pll_ctrl_q   <= 3'b111;
      pll_bypass_q <= 1'b1;
      reset_ext_q  <= 1'b0;
      trim_q       <= 8'd0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sck_sync_q   <= sck_sync_d;
      csb_sync_q   <= csb_sync_d;
      sdi_sync_q   <= sdi_sync_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_in_q   <= shift_in_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      sdo_sr_q     <= sdo_sr_d;
      pll_ctrl_q   <= pll_ctrl_d;
      pll_bypass_q <= pll_bypass_d;
      reset_ext_q  <= reset_ext_d;
      trim_q       <= trim_d;
      irq_q        <= irq_d;
    end
  end

  assign spi.SDO     = data_rd ? sdo_sr_q[7] : 1'b0;
  assign spi.sdo_enb = ~data_rd;
  assign pll_ctrl    = pll_ctrl_q;
  assign pll_bypass  = pll_bypass_q;
  assign reset_ext   = reset_ext_q;
  assign trim        = trim_q;
  assign irq         = irq_q;
endmodule

// File: tb/tb_hkspi_slave.sv
// tb/tb_hkspi_slave.sv - random and directed SPI transactions against a register-map model
module tb_hkspi_slave;
  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] pll_ctrl;
  logic       pll_bypass, irq, reset_ext;
  logic [7:0] trim;

  always #5 clk = ~clk;

  hkspi_slave_if spi();

  hkspi_slave dut (
    .clk(clk), .resetn(resetn), .spi(spi),
    .pll_ctrl(pll_ctrl), .pll_bypass(pll_bypass), .irq(irq),
    .reset_ext(reset_ext), .trim(trim)
  );

  int checks = 0;
  int passes = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  logic [7:0] tx_buf[16];

  logic [2:0] m_pll_ctrl;
  logic       m_bypass, m_reset_ext;
  logic [7:0] m_trim;
  int         m_irq_cnt = 0;
  int         irq_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  function automatic void model_reset();
    m_pll_ctrl  = 3'd7;
    m_bypass    = 1'b1;
    m_reset_ext = 1'b0;
    m_trim      = 8'h00;
  endfunction

  function automatic logic [7:0] model_read(input logic [7:0] a);
    if (a == 8'd1) return 8'h04;
    if (a == 8'd2) return 8'h56;
    if (a == 8'd3) return 8'h05;
    if (a == 8'd4) return {5'b0, m_pll_ctrl};
    if (a == 8'd5) return {7'b0, m_bypass};
    if (a == 8'd7) return {7'b0, m_reset_ext};
    if (a == 8'd8) return m_trim;
    return 8'h00;
  endfunction

  function automatic void model_write(input logic [7:0] a, input logic [7:0] d);
    if (a == 8'd4) m_pll_ctrl = d[2:0];
    if (a == 8'd5) m_bypass = d[0];
    if (a == 8'd7) m_reset_ext = d[0];
    if (a == 8'd8) m_trim = d;
`ifdef HKSPI_IRQ_EN
    if (a == 8'd6 && d[0]) m_irq_cnt++;
`endif
  endfunction

  task automatic check_regs(input string tag);
    chk({tag, ".pll_ctrl"}, pll_ctrl, m_pll_ctrl);
    chk({tag, ".pll_bypass"}, pll_bypass, m_bypass);
    chk({tag, ".reset_ext"}, reset_ext, m_reset_ext);
    chk({tag, ".trim"}, trim, m_trim);
  endtask

  // Host side: SDI set at the start of SCK low, SDO sampled at the end of SCK low.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, input logic exp_enb,
                          input bit chk_after, output logic [7:0] rx);
    logic enb_seen;
    enb_seen = exp_enb;
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi.SDI = tx[7-i];
      repeat (6) @(negedge clk);
      rx = {rx[6:0], spi.SDO};
      if (spi.sdo_enb !== exp_enb) enb_seen = spi.sdo_enb;
      spi.SCK = 1'b1;
      repeat (4) @(negedge clk);
      if (chk_after && i == nbits - 1) check_regs("commit4");
      repeat (2) @(negedge clk);
      spi.SCK = 1'b0;
    end
    chk("sdo_enb", enb_seen, exp_enb);
  endtask

  task automatic txn(input logic [7:0] cmd, input logic [7:0] addr, input int n);
    logic [7:0] rx, ptr;
    logic rd, wr;
    rd = cmd[6];
    wr = cmd[7];
    spi.CSB = 1'b0;
    repeat (6) @(negedge clk);
    spi_bits(cmd, 8, 1'b1, 1'b0, rx);
    spi_bits(addr, 8, 1'b1, 1'b0, rx);
    ptr = addr;
    for (int k = 0; k < n; k++) begin
      if (rd) exp_q.push_back(model_read(ptr));
      if (wr) model_write(ptr, tx_buf[k]);
      spi_bits(tx_buf[k], 8, !rd, wr && (k == n - 1), rx);
      if (rd) obs_q.push_back(rx);
      ptr = ptr + 8'd1;
    end
    spi.CSB = 1'b1;
    repeat (6) @(negedge clk);
    chk("idle.sdo_enb", spi.sdo_enb, 1'b1);
    check_regs("txn");
  endtask

  initial begin
    logic [7:0] o;
    forever begin
      @(negedge clk);
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL rd_orphan: got %0h expected none", o);
        end else begin
          chk("rd_data", o, exp_q.pop_front());
        end
      end
    end
  end

  always @(negedge clk) if (irq === 1'b1) irq_cnt++;

  initial begin
    logic [7:0] rx, a, c;
    int n;
    spi.SCK = 1'b0;
    spi.CSB = 1'b1;
    spi.SDI = 1'b0;
    resetn  = 1'b0;
    for (int i = 0; i < 16; i++) tx_buf[i] = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check_regs("reset");
    chk("reset.sdo_enb", spi.sdo_enb, 1'b1);
    chk("reset.sdo", spi.SDO, 1'b0);
    chk("reset.irq", irq, 1'b0);

    txn(8'h40, 8'h03, 1);
    txn(8'h40, 8'h00, 9);
    tx_buf[0] = 8'h01; txn(8'h80, 8'h07, 1);
    tx_buf[0] = 8'h00; txn(8'h80, 8'h07, 1);
    tx_buf[0] = 8'h01; txn(8'h80, 8'h06, 1);
    tx_buf[0] = 8'hA5; tx_buf[1] = 8'h3C; txn(8'h80, 8'h08, 2);
    tx_buf[0] = 8'h5A; txn(8'hC0, 8'h08, 1);
    txn(8'h40, 8'hFF, 2);

    // Partial byte then CSB high: trim must hold and the next read must re-sync.
    spi.CSB = 1'b0;
    repeat (6) @(negedge clk);
    spi_bits(8'h80, 8, 1'b1, 1'b0, rx);
    spi_bits(8'h08, 8, 1'b1, 1'b0, rx);
    spi_bits(8'hFF, 4, 1'b1, 1'b0, rx);
    spi.CSB = 1'b1;
    repeat (6) @(negedge clk);
    check_regs("abort");
    txn(8'h40, 8'h03, 1);

    for (int it = 0; it < 40; it++) begin
      c = 8'($urandom);
      a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 11)) : 8'($urandom_range(248, 255));
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) tx_buf[k] = 8'($urandom);
      txn(c, a, n);
    end

    // Reset in the middle of a write transaction.
    spi.CSB = 1'b0;
    repeat (6) @(negedge clk);
    spi_bits(8'h80, 8, 1'b1, 1'b0, rx);
    spi_bits(8'h08, 8, 1'b1, 1'b0, rx);
    spi_bits(8'h3C, 3, 1'b1, 1'b0, rx);
    resetn = 1'b0;
    model_reset();
    @(negedge clk);
    check_regs("midrst");
    chk("midrst.sdo_enb", spi.sdo_enb, 1'b1);
    resetn = 1'b1;
    spi.CSB = 1'b1;
    repeat (6) @(negedge clk);
    txn(8'h40, 8'h04, 2);

    for (int i = 0; i < 200 && obs_q.size() > 0; i++) @(negedge clk);
    chk("obs_drain", obs_q.size(), 0);
    chk("exp_drain", exp_q.size(), 0);
    chk("irq_pulses", irq_cnt, m_irq_cnt);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/hkspi_slave.md
# hkspi_slave

Housekeeping SPI slave: the on-chip end of the four-wire housekeeping port (SCK, CSB, SDI, SDO) driven by an external host or the chip-level testbench. Oversamples SPI pins on the system clock, decodes a command / address / streamed-data protocol, and serves a nine-entry register map (ID bytes, PLL control, IRQ trigger, external reset, trim). Its register outputs feed the clocking, reset and interrupt logic of the SoC.

## Interface
- `MFGR_ID`, 12'h456, manufacturer ID; reg 1 = {4'h0, MFGR_ID[11:8]}, reg 2 = MFGR_ID[7:0]
- `PROD_ID`, 8'h05, product ID; reg 3
- `clk` input 1: single system clock; all logic on rising edge
- `resetn` input 1: asynchronous, active-low reset
- `SCK` input 1: SPI clock, asynchronous to `clk`
- `CSB` input 1: SPI chip select, active low, asynchronous
- `SDI` input 1: SPI serial data in
- `SDO` output 1: SPI serial data out, MSB first
- `sdo_enb` output 1: active-low SDO pad enable; low only in DATA state of read-type transactions
- `pll_ctrl` output 3: reg 4 [2:0]
- `pll_bypass` output 1: reg 5 [0]
- `irq` output 1: one-cycle pulse from reg 6 write
- `reset_ext` output 1: reg 7 [0]
- `trim` output 8: reg 8

## Operation
- `SCK`, `CSB`, `SDI` each pass a 2-flop synchronizer; third flop on `SCK` gives rise/fall detect. All decisions use synchronized signals.
- States: IDLE, COMMAND, ADDRESS, DATA, IGNORE. Synced `CSB` high forces IDLE from any state next cycle; bit counter cleared, partial byte discarded, `sdo_enb`=1. Register contents never affected by abort.
- IDLE -> COMMAND on synced `CSB` low.
- SDI sampled on each detected SCK rise; 3-bit counter; byte complete on 8th rise.
- COMMAND byte: [7:6]=01 read stream, 10 write stream, 11 read+write stream, 00 -> IGNORE until CSB high. [5:0] ignored. -> ADDRESS.
- ADDRESS byte: loads 8-bit address pointer; for read types, register at that address loaded into SDO shift register same cycle; -> DATA.
- DATA: each SCK rise shifts SDO to next bit. On each completed byte: write types commit byte to current address; pointer increments (0xFF wraps to 0x00); read types load register at new pointer. Read+write: value loaded for read is pre-write contents.
- Register map: 0 = 0x00 RO; 1, 2 = MFGR_ID RO; 3 = PROD_ID RO; 4 = {5'b0, pll_ctrl} RW, reset 0x07; 5 = {7'b0, pll_bypass} RW, reset 0x01; 6 = IRQ trigger, reads 0x00; 7 = {7'b0, reset_ext} RW, reset 0x00; 8 = trim RW, reset 0x00. Addresses 9-0xFF read 0x00, writes ignored. Writes to RO regs ignored; unused bits of 4/5/7 read 0.
- `SDO` = 0 whenever not in DATA of a read type.

## Timing
- Reset values: `SDO`=0, `sdo_enb`=1, `pll_ctrl`=3'b111, `pll_bypass`=1, `irq`=0, `reset_ext`=0, `trim`=0x00, state IDLE, pointer 0.
- SCK rise to internal detect: 3 `clk` cycles. SDO update and register commit occur in that detect cycle; register outputs visible 1 cycle later (4 `clk` after SCK rise).
- Host samples SDO while SCK low, before rise; SDO changes ≤4 `clk` after rise, within SCK high phase.
- Requirements: SCK high and low each ≥4 `clk`; CSB low ≥4 `clk` before first SCK rise; CSB high ≥4 `clk` between transactions.
- Reset mid-transaction: immediate return to reset values regardless of SPI pins.

## Configuration
- `HKSPI_IRQ_EN` defined: write to reg 6 with bit0=1 pulses `irq` high exactly one `clk` cycle at commit; reg 6 always reads 0x00.
- Undefined: reg 6 writes ignored, `irq` tied 0, reg 6 reads 0x00.

## Test plan
- Reset, no SPI activity -> `pll_ctrl`=7, `pll_bypass`=1, `reset_ext`=0, `trim`=0x00, `sdo_enb`=1, `irq`=0.
- CSB low, send 0x40, 0x03, read one byte -> 0x05; `sdo_enb` low only during data byte.
- Send 0x40, 0x00, read nine bytes -> 00 04 56 05 07 01 00 00 00.
- Send 0x80 0x07 0x01 -> `reset_ext`=1 within 4 `clk` of 8th data SCK rise; 0x80 0x07 0x00 -> 0; with `HKSPI_IRQ_EN`, 0x80 0x06 0x01 -> single-cycle `irq`.
- Send 0x80 0x08 0xA5 0x3C -> `trim`=0xA5, address 9 write ignored; 0xC0 0x08 0x5A returns 0xA5 then `trim`=0x5A; 0x40 0xFF reads 0x00 then 0x00 (wrap to reg 0).
- Send 0x80 0x08 plus 4 bits, raise CSB -> `trim` unchanged; next 0x40 0x03 read returns 0x05 (clean re-sync).
